// File: rtl/demux_rr_dispatcher.sv
// demux_rr_dispatcher: takes one beat at a time from a valid/ready source and
// presents it to one of four consumers. The consumer is picked round-robin
// among the enabled channels.
//
// Handshake rule on both sides: a beat moves on the rising edge where valid
// and ready are both high. A valid that has been raised stays high, with its
// data unchanged, until that edge.
//
// The optional per-channel beat counters are built only when the macro
// DEMUX_DISP_STATS_EN is defined.
module demux_rr_dispatcher #(
    parameter int DATA_W = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [3:0]        ch_en,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        sel,
    output logic              busy
`ifdef DEMUX_DISP_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [4*CNT_W-1:0] beat_cnt
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_hold;
    logic [1:0]        r_sel;
    logic [1:0]        r_ptr;
    logic [3:0]        r_out_valid;
    logic              r_busy;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_done;
    logic [1:0]        w_grant;
    logic              w_grant_ok;
    logic [1:0]        w_cand;

    // Round-robin search: ptr+1, ptr+2, ptr+3, then ptr itself.
    always_comb begin
        w_grant    = r_ptr;
        w_grant_ok = 1'b0;
        w_cand     = r_ptr;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_ptr + 2'(k);
            if (!w_grant_ok && ch_en[w_cand]) begin
                w_grant    = w_cand;
                w_grant_ok = 1'b1;
            end
        end
    end

    // Next state and handshake decode. in_ready depends only on the state
    // and ch_en, never on in_valid.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = |ch_en;
                if (in_valid && w_in_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                // The grant was fixed at capture. Only the selected
                // channel's ready can release the beat.
                if (out_ready[r_sel]) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Datapath: capture the beat and grant on accept, release on delivery.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold      <= '0;
            r_sel       <= 2'd0;
            r_ptr       <= 2'd3;
            r_out_valid <= 4'b0000;
            r_busy      <= 1'b0;
        end else if (w_accept) begin
            r_hold      <= in_data;
            r_sel       <= w_grant;
            r_out_valid <= 4'b0001 << w_grant;
            r_busy      <= 1'b1;
        end else if (w_done) begin
            r_ptr       <= r_sel;
            r_out_valid <= 4'b0000;
            r_busy      <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_hold;
    assign sel       = r_sel;
    assign busy      = r_busy;

`ifdef DEMUX_DISP_STATS_EN
    logic [CNT_W-1:0] r_cnt [4];

    // Saturating per-channel delivery counters. A clear wins over a
    // coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (stats_clr)
                    r_cnt[i] <= '0;
                else if (w_done && (r_sel == 2'(i)) && (r_cnt[i] != {CNT_W{1'b1}}))
                    r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_cnt_out
        assign beat_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
    end
`endif

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Bench for demux_rr_dispatcher. A queue-based reference model tracks the
// round-robin pointer, the beats in flight and the saturating counters.
module tb_demux_rr_dispatcher;

    localparam int DATA_W = 1;
`ifdef DEMUX_DISP_STATS_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 8;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [3:0]        ch_en = 4'b0000;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready = 4'b0000;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        sel;
    logic              busy;
`ifdef DEMUX_DISP_STATS_EN
    logic              stats_clr = 1'b0;
    logic [4*CNT_W-1:0] beat_cnt;
`endif

    demux_rr_dispatcher #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .ch_en(ch_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sel(sel), .busy(busy)
`ifdef DEMUX_DISP_STATS_EN
        , .stats_clr(stats_clr), .beat_cnt(beat_cnt)
`endif
    );

    // Clock and reset.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    int m_ptr;
    int m_cnt [4];
    logic [DATA_W-1:0] exp_q [$];

    // Returns the first enabled channel after the last served one,
    // wrapping around. Returns -1 when no channel is enabled.
    function automatic int model_grant(input logic [3:0] en);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_ptr + k) % 4;
            if (en[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 3;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        exp_q.delete();
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
`ifdef DEMUX_DISP_STATS_EN
        stats_clr = 1'b0;
`endif
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // Sends one beat and delivers it after 'stall' cycles of backpressure.
    // During the stall, the non-selected ready bits come from stall_rdy.
    // With drop_en set, the granted channel is disabled while the beat is held.
    // With clr set, stats_clr is raised on the delivery edge.
    task automatic do_beat(input logic [3:0] en, input logic [DATA_W-1:0] data,
                           input int stall, input logic [3:0] stall_rdy,
                           input bit drop_en, input bit clr);
        int ch;
        logic [3:0] exp_ov;
        ch = model_grant(en);
        exp_ov = 4'b0001 << ch;
        ch_en = en; in_data = data; in_valid = 1'b1; out_ready = 4'b0000;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready act=%b exp=1", in_ready); else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back(data);
        n_checks++; if (sel !== 2'(ch)) $display("FAIL grant_sel act=%0d exp=%0d", sel, ch); else n_pass++;
        n_checks++; if (out_valid !== exp_ov) $display("FAIL grant_ov act=%b exp=%b", out_valid, exp_ov); else n_pass++;
        n_checks++; if (out_data !== exp_q[0]) $display("FAIL grant_data act=%b exp=%b", out_data, exp_q[0]); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL send_busy act=%b exp=1", busy); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL send_in_ready act=%b exp=0", in_ready); else n_pass++;
        if (drop_en) ch_en = en & ~exp_ov;
        for (int s = 0; s < stall; s++) begin
            out_ready = stall_rdy & ~exp_ov;
            @(posedge clk); #1;
            n_checks++; if (out_valid !== exp_ov) $display("FAIL hold_ov act=%b exp=%b", out_valid, exp_ov); else n_pass++;
            n_checks++; if (out_data !== exp_q[0]) $display("FAIL hold_data act=%b exp=%b", out_data, exp_q[0]); else n_pass++;
            n_checks++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready act=%b exp=0", in_ready); else n_pass++;
        end
        out_ready = exp_ov;
`ifdef DEMUX_DISP_STATS_EN
        stats_clr = clr;
`endif
        @(posedge clk); #1;
        out_ready = 4'b0000;
`ifdef DEMUX_DISP_STATS_EN
        stats_clr = 1'b0;
`endif
        void'(exp_q.pop_front());
        m_ptr = ch;
        if (clr) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        else if (m_cnt[ch] < (1 << CNT_W) - 1) m_cnt[ch]++;
        n_checks++; if (out_valid !== 4'b0000) $display("FAIL done_ov act=%b exp=0000", out_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL done_busy act=%b exp=0", busy); else n_pass++;
        n_checks++; if (in_ready !== (|ch_en)) $display("FAIL done_in_ready act=%b exp=%b", in_ready, |ch_en); else n_pass++;
`ifdef DEMUX_DISP_STATS_EN
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (beat_cnt[i*CNT_W +: CNT_W] !== CNT_W'(m_cnt[i]))
                $display("FAIL beat_cnt%0d act=%0d exp=%0d", i, beat_cnt[i*CNT_W +: CNT_W], m_cnt[i]);
            else n_pass++;
        end
`endif
    endtask

    task automatic test_reset();
        ch_en = 4'b0000;
        #3;
        n_checks++; if (out_valid !== 4'b0000) $display("FAIL rst_ov act=%b exp=0000", out_valid); else n_pass++;
        n_checks++; if (sel !== 2'd0) $display("FAIL rst_sel act=%0d exp=0", sel); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy act=%b exp=0", busy); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL rst_data act=%b exp=0", out_data); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready act=%b exp=0", in_ready); else n_pass++;
        apply_reset();
    endtask

    task automatic test_all_enabled();
        logic [7:0] pat;
        pat = 8'b0100_1101;
        // Beat j carries pat[j]: 1,0,1,1,0,0,1,0. Grants go 0,1,2,3,0,1,2,3.
        for (int j = 0; j < 8; j++) do_beat(4'b1111, DATA_W'(pat[j]), 0, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_mask_1010();
        for (int j = 0; j < 4; j++) do_beat(4'b1010, DATA_W'($urandom_range(1, 0)), 0, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_beat(4'b0100, 1'b1, 5, 4'b0001, 1'b0, 1'b0);
    endtask

    task automatic test_no_enable();
        ch_en = 4'b0000; in_valid = 1'b1; in_data = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #1;
            n_checks++; if (in_ready !== 1'b0) $display("FAIL noen_in_ready act=%b exp=0", in_ready); else n_pass++;
            @(posedge clk); #1;
            n_checks++; if (out_valid !== 4'b0000) $display("FAIL noen_ov act=%b exp=0000", out_valid); else n_pass++;
            n_checks++; if (busy !== 1'b0) $display("FAIL noen_busy act=%b exp=0", busy); else n_pass++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_clear_en_mid_send();
        do_beat(4'b1111, 1'b1, 3, 4'b1111, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_send();
        ch_en = 4'b1111; in_valid = 1'b1; in_data = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL pre_rst_busy act=%b exp=1", busy); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 4'b0000) $display("FAIL async_rst_ov act=%b exp=0000", out_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL async_rst_busy act=%b exp=0", busy); else n_pass++;
        n_checks++; if (sel !== 2'd0) $display("FAIL async_rst_sel act=%0d exp=0", sel); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL async_rst_data act=%b exp=0", out_data); else n_pass++;
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        // The first grant after reset must be channel 0.
        do_beat(4'b1111, 1'b0, 0, 4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int j = 0; j < 24; j++) begin
            logic [3:0] en;
            en = 4'($urandom_range(15, 1));
            do_beat(en, DATA_W'($urandom), $urandom_range(3, 0), 4'($urandom), 1'b0, 1'b0);
        end
    endtask

`ifdef DEMUX_DISP_STATS_EN
    task automatic test_stats();
        apply_reset();
        for (int j = 0; j < 5; j++) do_beat(4'b0001, 1'b1, 0, 4'b0000, 1'b0, 1'b0);
        do_beat(4'b0001, 1'b0, 1, 4'b0000, 1'b0, 1'b1);
    endtask
`endif

    // Scenario sequence and final report.
    initial begin
        model_reset();
        test_reset();
        test_all_enabled();
        test_mask_1010();
        test_backpressure();
        test_no_enable();
        test_clear_en_mid_send();
        test_reset_mid_send();
        test_random();
`ifdef DEMUX_DISP_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
